// File: rtl/key_debounce_if.sv
// Button conditioner signal bundle: raw pin in, debounced level, strobes and press count out.
// slave is the conditioner side, master is the side that drives the pin and consumes the results.
interface key_debounce_if;
  logic       key_in;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport slave (
    input  key_in,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output press_count
  );

  modport master (
    output key_in,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  press_count
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop sync + 4-state filter; press/release accepted DEBOUNCE_CYCLES+2 edges after the pin settles.
// No backpressure: strobes are single-cycle and unconditional, press_count wraps modulo 256.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam logic        IDLE_LVL  = ACTIVE_LOW;
  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] LONG_SAT  = 32'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_s1, r_s2;
  logic        w_act;
  logic [31:0] r_dcnt, w_dcnt_nxt;
  logic [31:0] r_hcnt, w_hcnt_nxt;
  logic        r_key_level, w_key_level_nxt;
  logic        r_press_pulse, w_press_pulse_nxt;
  logic        r_release_pulse, w_release_pulse_nxt;
  logic        r_long_pulse, w_long_pulse_nxt;
  logic [7:0]  r_press_count, w_press_count_nxt;

  // Reset loads the idle pin level so a held key is not seen as pressed until it clears the sync chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= IDLE_LVL;
      r_s2 <= IDLE_LVL;
    end else begin
      r_s1 <= bus.key_in;
      r_s2 <= r_s1;
    end
  end

  assign w_act = r_s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_dcnt          <= '0;
      r_hcnt          <= '0;
      r_key_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_dcnt          <= w_dcnt_nxt;
      r_hcnt          <= w_hcnt_nxt;
      r_key_level     <= w_key_level_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_long_pulse    <= w_long_pulse_nxt;
      r_press_count   <= w_press_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_dcnt_nxt          = r_dcnt;
    w_hcnt_nxt          = r_hcnt;
    w_key_level_nxt     = r_key_level;
    w_press_pulse_nxt   = 1'b0;
    w_release_pulse_nxt = 1'b0;
    w_long_pulse_nxt    = 1'b0;
    w_press_count_nxt   = r_press_count;

    case (r_state)
      IDLE: begin
        if (w_act) begin
          w_state_nxt = PRESS_CHK;
          w_dcnt_nxt  = '0;
        end
      end

      PRESS_CHK: begin
        if (!w_act) begin
          w_state_nxt = IDLE;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt       = HELD;
          w_key_level_nxt   = 1'b1;
          w_press_pulse_nxt = 1'b1;
          w_press_count_nxt = r_press_count + 8'd1;
          w_hcnt_nxt        = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 32'd1;
        end
      end

      HELD: begin
        if (!w_act) begin
          w_state_nxt = RELEASE_CHK;
          w_dcnt_nxt  = '0;
        end else if (r_hcnt == LONG_LAST) begin
          // Parking at LONG_CYCLES keeps long_pulse to one shot per press.
          w_long_pulse_nxt = 1'b1;
          w_hcnt_nxt       = LONG_SAT;
        end else if (r_hcnt < LONG_LAST) begin
          w_hcnt_nxt = r_hcnt + 32'd1;
        end
      end

      RELEASE_CHK: begin
        if (w_act) begin
          w_state_nxt = HELD;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt         = IDLE;
          w_key_level_nxt     = 1'b0;
          w_release_pulse_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + 32'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.key_level     = r_key_level;
  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign bus.long_pulse    = r_long_pulse;
  assign bus.press_count   = r_press_count;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
module tb_key_debounce;

  logic clk;
  logic rst;

  key_debounce_if bus();

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int press_n = 0;
  int rel_n = 0;
  int long_n = 0;
  int ovl_n = 0;

  always @(negedge clk) begin
    if (bus.press_pulse)   press_n <= press_n + 1;
    if (bus.release_pulse) rel_n   <= rel_n + 1;
    if (bus.long_pulse)    long_n  <= long_n + 1;
    if ((bus.press_pulse && bus.release_pulse) || (bus.long_pulse && (bus.press_pulse || bus.release_pulse)))
      ovl_n <= ovl_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    bus.key_in = 1'b0;
    repeat (8) tick();
    bus.key_in = 1'b1;
    repeat (8) tick();
  endtask

  int p0, r0;

  initial begin
    rst = 1'b0;
    bus.key_in = 1'b1;
    #3;
    chk("rst_level", 32'(bus.key_level), 0);
    chk("rst_press", 32'(bus.press_pulse), 0);
    chk("rst_release", 32'(bus.release_pulse), 0);
    chk("rst_long", 32'(bus.long_pulse), 0);
    chk("rst_count", 32'(bus.press_count), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    // Clean press: next rising edge is edge 0
    bus.key_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("clean_press_pulse", 32'(bus.press_pulse), 32'(k == 6));
      chk("clean_level", 32'(bus.key_level), 32'(k >= 6));
    end
    chk("clean_count", 32'(bus.press_count), 1);

    // Keep holding: long_pulse exactly 20 edges after press_pulse (edge 26)
    for (int k = 8; k < 47; k++) begin
      tick();
      chk("long_pulse", 32'(bus.long_pulse), 32'(k == 26));
    end
    chk("long_once", 32'(long_n), 1);

    // Release glitch of 2 cycles while held
    p0 = press_n;
    r0 = rel_n;
    bus.key_in = 1'b1;
    tick();
    tick();
    bus.key_in = 1'b0;
    repeat (10) tick();
    chk("glitch_level", 32'(bus.key_level), 1);
    chk("glitch_no_release", 32'(rel_n), 32'(r0));
    chk("glitch_no_press", 32'(press_n), 32'(p0));
    chk("glitch_no_long", 32'(long_n), 1);

    // Stable release
    bus.key_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("release_pulse", 32'(bus.release_pulse), 32'(k == 6));
      chk("release_level", 32'(bus.key_level), 32'(k < 6));
    end
    chk("release_count", 32'(bus.press_count), 1);

    // Short press: release 10 edges after press_pulse, no long_pulse
    bus.key_in = 1'b0;
    repeat (7) tick();
    chk("short_press_pulse", 32'(bus.press_pulse), 1);
    repeat (9) tick();
    bus.key_in = 1'b1;
    repeat (12) tick();
    chk("short_no_long", 32'(long_n), 1);
    chk("short_level", 32'(bus.key_level), 0);
    chk("short_count", 32'(bus.press_count), 2);

    // Bounce: low 3, high 1, low 2, then high
    p0 = press_n;
    r0 = rel_n;
    bus.key_in = 1'b0;
    repeat (3) tick();
    bus.key_in = 1'b1;
    tick();
    bus.key_in = 1'b0;
    repeat (2) tick();
    bus.key_in = 1'b1;
    repeat (10) tick();
    chk("bounce_level", 32'(bus.key_level), 0);
    chk("bounce_no_press", 32'(press_n), 32'(p0));
    chk("bounce_no_release", 32'(rel_n), 32'(r0));
    chk("bounce_count", 32'(bus.press_count), 2);

    // Wrap: 253 more presses -> 255, one more -> 0
    repeat (253) press_release();
    chk("wrap_255", 32'(bus.press_count), 255);
    press_release();
    chk("wrap_0", 32'(bus.press_count), 0);
    chk("wrap_level", 32'(bus.key_level), 0);

    // Reset in PRESS_CHK, asserted between edges
    press_release();
    chk("pre_reset_count", 32'(bus.press_count), 1);
    bus.key_in = 1'b0;
    repeat (4) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.press_count), 0);
    chk("mid_rst_level", 32'(bus.key_level), 0);
    chk("mid_rst_press", 32'(bus.press_pulse), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_press_pulse", 32'(bus.press_pulse), 32'(k == 6));
    end
    chk("post_rst_count", 32'(bus.press_count), 1);

    chk("no_pulse_overlap", 32'(ovl_n), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
